// File: rtl/edge_event_pkg.sv
// Shared definitions for the edge event counter: MODE encodings, read FSM states
// and the channel-index width helper.
package edge_event_pkg;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } rd_state_e;

  // A single channel still needs a 1-bit select so the port never collapses.
  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/edge_event_counter_if.sv
// Counter read port. Master issues requests and accepts data; slave is the counter.
// Handshake: rd_req qualifies rd_ch only while rd_busy=0; rd_data/rd_ovf are held
// stable while rd_valid=1 and the transfer completes on a cycle with rd_valid & rd_ready.
interface edge_event_counter_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  import edge_event_pkg::*;

  localparam int CH_W = ch_w(CHANNELS);

  logic             rd_req;
  logic [CH_W-1:0]  rd_ch;
  logic             rd_ready;
  logic             rd_busy;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic             rd_ovf;

  modport master (
    output rd_req, rd_ch, rd_ready,
    input  rd_busy, rd_valid, rd_data, rd_ovf
  );

  modport slave (
    input  rd_req, rd_ch, rd_ready,
    output rd_busy, rd_valid, rd_data, rd_ovf
  );

endinterface

// File: rtl/edge_sync_det.sv
// One channel: SYNC_STAGES-deep synchroniser, one history flop and a MODE-selected
// edge detector producing a single-cycle event pulse.
module edge_sync_det
  import edge_event_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       in_i,
  input  logic [1:0] mode_i,
  output logic       event_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   cur;

  assign cur = sync_q[SYNC_STAGES-1];

  // History keeps tracking even when MODE_OFF so re-enabling sees no stale edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
      prev_q <= cur;
    end
  end

  always_comb begin
    event_o = 1'b0;
    case (mode_i)
      MODE_RISE: event_o = cur & ~prev_q;
      MODE_FALL: event_o = ~cur & prev_q;
      MODE_BOTH: event_o = cur ^ prev_q;
      default:   event_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/edge_event_counter.sv
// Multi-channel saturating edge counter with clear-on-read valid/ready read port.
// Define OVF_STICKY_EN for sticky per-channel overflow flags; otherwise RD_OVF means "read all-ones".
module edge_event_counter
  import edge_event_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [CHANNELS-1:0] in_i,
  input  logic [1:0]          mode_i,
  input  logic                clr_i,
  edge_event_counter_if.slave rd,
  output rd_state_e           state_o
);

  localparam int               CH_W    = ch_w(CHANNELS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CHANNELS-1:0] ev;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
`ifdef OVF_STICKY_EN
  logic [CHANNELS-1:0] ovf_q;
  logic [CHANNELS-1:0] ovf_d;
  logic                sel_flag;
`endif
  logic [CNT_W-1:0]    sel_cnt;
  logic                capture;

  rd_state_e           state_q, state_d;
  logic [CNT_W-1:0]    rd_data_q, rd_data_d;
  logic                rd_ovf_q, rd_ovf_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    edge_sync_det #(.SYNC_STAGES(SYNC_STAGES)) u_det (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .in_i    (in_i[g]),
      .mode_i  (mode_i),
      .event_o (ev[g])
    );
  end

  // Out-of-range selects match no channel and read back as zero.
  always_comb begin
    sel_cnt = '0;
`ifdef OVF_STICKY_EN
    sel_flag = 1'b0;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd.rd_ch == CH_W'(i)) begin
        sel_cnt = cnt_q[i];
`ifdef OVF_STICKY_EN
        sel_flag = ovf_q[i];
`endif
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    rd_ovf_d  = rd_ovf_q;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd.rd_req) begin
          capture   = 1'b1;
          state_d   = RESP;
          rd_data_d = sel_cnt;
`ifdef OVF_STICKY_EN
          rd_ovf_d  = sel_flag;
`else
          rd_ovf_d  = (sel_cnt == CNT_MAX);
`endif
        end
      end
      RESP: begin
        if (rd.rd_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // CLR wins over everything; a read-clear keeps a coinciding event as a count of one.
  always_comb begin
    cnt_d = cnt_q;
`ifdef OVF_STICKY_EN
    ovf_d = ovf_q;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      if (clr_i) begin
        cnt_d[i] = '0;
`ifdef OVF_STICKY_EN
        ovf_d[i] = 1'b0;
`endif
      end else if (capture && (rd.rd_ch == CH_W'(i))) begin
        cnt_d[i] = ev[i] ? CNT_W'(1) : '0;
`ifdef OVF_STICKY_EN
        ovf_d[i] = 1'b0;
`endif
      end else if (ev[i]) begin
        if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_W'(1);
`ifdef OVF_STICKY_EN
        else ovf_d[i] = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '{default: '0};
`ifdef OVF_STICKY_EN
      ovf_q     <= '0;
`endif
      state_q   <= IDLE;
      rd_data_q <= '0;
      rd_ovf_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
`ifdef OVF_STICKY_EN
      ovf_q     <= ovf_d;
`endif
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
      rd_ovf_q  <= rd_ovf_d;
    end
  end

  assign rd.rd_valid = (state_q == RESP);
  assign rd.rd_busy  = (state_q == RESP);
  assign rd.rd_data  = rd_data_q;
  assign rd.rd_ovf   = rd_ovf_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_edge_event_counter.sv
// Bench for edge_event_counter (3 channels, 4-bit counters): directed scenarios
// plus a randomized phase, every cycle compared against an event-level reference model.
module tb_edge_event_counter;
  import edge_event_pkg::*;

  localparam int CH   = 3;
  localparam int CW   = 4;
  localparam int SS   = 2;
  localparam int CHW  = ch_w(CH);
  localparam int MAXV = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [CH-1:0] in_v;
  logic [1:0]    mode;
  logic          clr;
  rd_state_e     state;

  always #5 clk = ~clk;

  edge_event_counter_if #(.CHANNELS(CH), .CNT_W(CW)) rd_bus ();

  edge_event_counter #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .in_i    (in_v),
    .mode_i  (mode),
    .clr_i   (clr),
    .rd      (rd_bus),
    .state_o (state)
  );

  // ---------------- scoreboard / reference model ----------------
  int            n_vec = 0;
  int            n_err = 0;
  int            m_cnt  [CH];
  bit            m_flag [CH];
  bit            m_busy;
  int            m_data;
  bit            m_ovf;
  logic [CH-1:0] samp_q[$];   // pin samples not yet seen by the edge evaluation

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i]  = 0;
      m_flag[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_data = 0;
    m_ovf  = 1'b0;
    samp_q = {};
    for (int i = 0; i <= SS; i++) samp_q.push_back('0);
  endtask

  // What the next rising edge does, given the inputs currently driven.
  task automatic model_step();
    logic [CH-1:0] prev_s, cur_s;
    bit            ev, cap;
    int            ch;
    prev_s = samp_q[0];
    cur_s  = samp_q[1];
    ch     = int'(rd_bus.rd_ch);
    cap    = 1'b0;
    if (!m_busy) begin
      if (rd_bus.rd_req) begin
        cap    = 1'b1;
        m_busy = 1'b1;
        m_data = (ch < CH) ? m_cnt[ch] : 0;
`ifdef OVF_STICKY_EN
        m_ovf  = (ch < CH) ? m_flag[ch] : 1'b0;
`else
        m_ovf  = (m_data == MAXV);
`endif
      end
    end else if (rd_bus.rd_ready) begin
      m_busy = 1'b0;
    end
    for (int i = 0; i < CH; i++) begin
      case (mode)
        2'b00:   ev = cur_s[i] && !prev_s[i];
        2'b01:   ev = !cur_s[i] && prev_s[i];
        2'b10:   ev = cur_s[i] != prev_s[i];
        default: ev = 1'b0;
      endcase
      if (clr) begin
        m_cnt[i] = 0; m_flag[i] = 1'b0;
      end else if (cap && ch == i) begin
        m_cnt[i] = ev ? 1 : 0; m_flag[i] = 1'b0;
      end else if (ev) begin
        if (m_cnt[i] == MAXV) m_flag[i] = 1'b1;
        else m_cnt[i] = m_cnt[i] + 1;
      end
    end
    samp_q.push_back(in_v);
    void'(samp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("rd_valid", rd_bus.rd_valid, m_busy);
    check("rd_busy", rd_bus.rd_busy, m_busy);
    check("state", state == RESP, m_busy);
    if (m_busy) begin
      check("rd_data", rd_bus.rd_data, m_data);
      check("rd_ovf", rd_bus.rd_ovf, m_ovf);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      in_v[ch] = 1'b1; tick(); tick();
      in_v[ch] = 1'b0; tick(); tick();
    end
    settle(SS + 2);
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic read_ch(input int ch, output int data, output bit ovf);
    rd_bus.rd_req   = 1'b1;
    rd_bus.rd_ch    = CHW'(ch);
    rd_bus.rd_ready = 1'b1;
    tick();
    rd_bus.rd_req = 1'b0;
    data = int'(rd_bus.rd_data);
    ovf  = rd_bus.rd_ovf;
    tick();
  endtask

  // ---------------- stimulus ----------------
  int d;
  bit o;
  int modes[3] = '{2, 1, 3};
  int exp_m[3] = '{6, 3, 0};

  initial begin
    in_v = '0; mode = MODE_RISE; clr = 1'b0;
    rd_bus.rd_req = 1'b0; rd_bus.rd_ch = '0; rd_bus.rd_ready = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", rd_bus.rd_valid, 0);
    check("rst_busy", rd_bus.rd_busy, 0);
    check("rst_data", rd_bus.rd_data, 0);
    check("rst_ovf", rd_bus.rd_ovf, 0);
    rst_n = 1'b1;

    // basic count and clear-on-read
    pulse(2, 5);
    read_ch(2, d, o); check("ch2_five", d, 5); check("ch2_five_ovf", o, 0);
    read_ch(2, d, o); check("ch2_reread", d, 0);

    // edge modes
    for (int m = 0; m < 3; m++) begin
      mode = modes[m][1:0];
      do_clr();
      pulse(0, 3);
      read_ch(0, d, o); check("mode_cnt", d, exp_m[m]);
    end

    // latency: the edge lands exactly SS+1 edges after the pin changes
    mode = MODE_RISE; do_clr();
    in_v[0] = 1'b1;
    settle(SS);
    read_ch(0, d, o); check("lat_early", d, 0);
    read_ch(0, d, o); check("lat_kept", d, 1);
    in_v[0] = 1'b0; settle(SS + 2);

    // saturation
    do_clr();
    pulse(1, 15);
    read_ch(1, d, o); check("sat15", d, 15);
`ifdef OVF_STICKY_EN
    check("sat15_ovf", o, 0);
`else
    check("sat15_ovf", o, 1);
`endif
    pulse(1, 16);
    read_ch(1, d, o); check("sat16", d, 15); check("sat16_ovf", o, 1);
    pulse(1, 20);
    read_ch(1, d, o); check("sat20", d, 15); check("sat20_ovf", o, 1);

    // handshake back-pressure; a request during RESP is ignored
    pulse(1, 4);
    rd_bus.rd_req = 1'b1; rd_bus.rd_ch = CHW'(1); rd_bus.rd_ready = 1'b0;
    tick();
    rd_bus.rd_ch = CHW'(3);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("hs_valid", rd_bus.rd_valid, 1);
      check("hs_busy", rd_bus.rd_busy, 1);
      check("hs_data", rd_bus.rd_data, 4);
    end
    rd_bus.rd_req = 1'b0; rd_bus.rd_ready = 1'b1;
    tick();
    check("hs_idle", rd_bus.rd_valid, 0);
    read_ch(1, d, o); check("hs_cleared", d, 0);

    // collision of read-clear with an event
    pulse(0, 7);
    in_v[0] = 1'b1;
    settle(SS);
    read_ch(0, d, o); check("coll_data", d, 7);
    read_ch(0, d, o); check("coll_next", d, 1);
    in_v[0] = 1'b0; settle(SS + 2);

    // CLR coinciding with an event
    pulse(1, 2); pulse(2, 3);
    in_v[0] = 1'b1;
    settle(SS);
    do_clr();
    in_v[0] = 1'b0; settle(SS + 2);
    for (int c = 0; c < CH; c++) begin
      read_ch(c, d, o); check("clr_all", d, 0);
    end

    // out-of-range channel
    pulse(2, 3);
    read_ch(3, d, o); check("oor_data", d, 0); check("oor_ovf", o, 0);
    read_ch(2, d, o); check("oor_other", d, 3);

    // randomized phase
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 3) == 0) in_v[i] = ~in_v[i];
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      clr             = ($urandom_range(0, 39) == 0);
      rd_bus.rd_req   = ($urandom_range(0, 2) == 0);
      rd_bus.rd_ch    = CHW'($urandom_range(0, 3));
      rd_bus.rd_ready = ($urandom_range(0, 1) == 0);
      tick();
    end
    clr = 1'b0; rd_bus.rd_req = 1'b0; rd_bus.rd_ready = 1'b1; in_v = '0;
    settle(SS + 3);

    // reset in the middle of a read
    mode = MODE_RISE;
    pulse(0, 2);
    rd_bus.rd_req = 1'b1; rd_bus.rd_ch = CHW'(0); rd_bus.rd_ready = 1'b0;
    tick();
    check("mid_valid_pre", rd_bus.rd_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_valid", rd_bus.rd_valid, 0);
    check("mid_busy", rd_bus.rd_busy, 0);
    check("mid_data", rd_bus.rd_data, 0);
    check("mid_ovf", rd_bus.rd_ovf, 0);
    model_reset();
    rd_bus.rd_req = 1'b0;
    #2 rst_n = 1'b1;
    read_ch(0, d, o); check("mid_after", d, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
